tl_execute_stage: RTL and testbench

//  MIPS 32-bit execute (EX) stage with integrated EX/MEM pipeline register.

---
 rtl/tl_execute_stage_pkg.sv | 66 ++++++
 rtl/tl_execute_stage_if.sv | 37 +++
 rtl/tl_execute_stage_alu.sv | 34 +++
 rtl/tl_execute_stage_alu_control.sv | 43 ++++
 rtl/tl_execute_stage.sv | 89 ++++++++
 tb/tb_tl_execute_stage.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/tl_execute_stage_pkg.sv
// Shared constants for the MIPS execute stage: datapath widths, ALU operation
// codes, main-decoder alu_op encodings, R-type funct values and ctrl_ex bit positions.
package tl_execute_stage_pkg;

  localparam int LEN                  = 32;
  localparam int NB_ADDRESS_REGISTROS = 5;
  localparam int NB_ALU_CONTROL       = 4;
  localparam int NB_CTRL_WB           = 2;
  localparam int NB_CTRL_MEM          = 3;
  localparam int NB_CTRL_EX           = 7;

  localparam int CTRL_EX_REG_DST   = 6;
  localparam int CTRL_EX_ALU_SRC   = 5;
  localparam int CTRL_EX_ALU_OP_HI = 4;
  localparam int CTRL_EX_ALU_OP_LO = 2;

  typedef enum logic [NB_ALU_CONTROL-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLLV = 4'b1001,
    ALU_SRLV = 4'b1010,
    ALU_SRAV = 4'b1011,
    ALU_NOR  = 4'b1100,
    ALU_LUI  = 4'b1101
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_XOR   = 3'b101,
    ALUOP_SLT   = 3'b110,
    ALUOP_LUI   = 3'b111
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  // Immediate logic ops take the zero-extended immediate, not the sign-extended one.
  function automatic logic is_logic_imm(input alu_op_e op);
    return (op == ALUOP_AND) || (op == ALUOP_OR) || (op == ALUOP_XOR);
  endfunction

endpackage

// File: rtl/tl_execute_stage_if.sv
// ID/EX operand+control bundle in, EX/MEM register bundle out.
// master = ID-side driver, slave = execute stage.
interface tl_execute_stage_if;
  import tl_execute_stage_pkg::*;

  logic [LEN-1:0]                  i_adder_id;
  logic [LEN-1:0]                  i_dato1;
  logic [LEN-1:0]                  i_dato2;
  logic [LEN-1:0]                  i_sign_extend;
  logic [NB_CTRL_WB-1:0]           i_ctrl_wb;
  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem;
  logic [NB_CTRL_EX-1:0]           i_ctrl_ex;
  logic [NB_ADDRESS_REGISTROS-1:0] i_rd;
  logic [NB_ADDRESS_REGISTROS-1:0] i_rt;

  logic                            o_alu_zero;
  logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg;
  logic [NB_CTRL_WB-1:0]           o_ctrl_wb;
  logic [NB_CTRL_MEM-1:0]          o_ctrl_mem;
  logic [LEN-1:0]                  o_add_excute;
  logic [LEN-1:0]                  o_alu_result;
  logic [LEN-1:0]                  o_dato2;

  modport master (
    output i_adder_id, i_dato1, i_dato2, i_sign_extend, i_ctrl_wb, i_ctrl_mem,
           i_ctrl_ex, i_rd, i_rt,
    input  o_alu_zero, o_write_reg, o_ctrl_wb, o_ctrl_mem, o_add_excute,
           o_alu_result, o_dato2
  );

  modport slave (
    input  i_adder_id, i_dato1, i_dato2, i_sign_extend, i_ctrl_wb, i_ctrl_mem,
           i_ctrl_ex, i_rd, i_rt,
    output o_alu_zero, o_write_reg, o_ctrl_wb, o_ctrl_mem, o_add_excute,
           o_alu_result, o_dato2
  );
endinterface

// File: rtl/tl_execute_stage_alu.sv
// Purely combinational 32-bit ALU; shifts act on operand B.
module tl_execute_stage_alu
  import tl_execute_stage_pkg::*;
(
  input  alu_ctrl_e      op_i,
  input  logic [LEN-1:0] a_i,
  input  logic [LEN-1:0] b_i,
  input  logic [4:0]     shamt_i,
  input  logic [15:0]    imm_i,
  output logic [LEN-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLT:  result_o = {{(LEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLL:  result_o = b_i << shamt_i;
      ALU_SRL:  result_o = b_i >> shamt_i;
      ALU_SRA:  result_o = $unsigned($signed(b_i) >>> shamt_i);
      ALU_SLLV: result_o = b_i << a_i[4:0];
      ALU_SRLV: result_o = b_i >> a_i[4:0];
      ALU_SRAV: result_o = $unsigned($signed(b_i) >>> a_i[4:0]);
      ALU_LUI:  result_o = {imm_i, {(LEN-16){1'b0}}};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/tl_execute_stage_alu_control.sv
// Maps the main-decoder alu_op and the R-type funct field to a 4-bit ALU operation.
module tl_execute_stage_alu_control
  import tl_execute_stage_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [5:0] funct_i,
  output alu_ctrl_e  alu_ctrl_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives the output; no latch is inferred.
    alu_ctrl_o = ALU_ADD;
    unique case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_AND: alu_ctrl_o = ALU_AND;
      ALUOP_OR:  alu_ctrl_o = ALU_OR;
      ALUOP_XOR: alu_ctrl_o = ALU_XOR;
      ALUOP_SLT: alu_ctrl_o = ALU_SLT;
      ALUOP_LUI: alu_ctrl_o = ALU_LUI;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD, FUNCT_ADDU: alu_ctrl_o = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_ctrl_o = ALU_SUB;
          FUNCT_AND:             alu_ctrl_o = ALU_AND;
          FUNCT_OR:              alu_ctrl_o = ALU_OR;
          FUNCT_XOR:             alu_ctrl_o = ALU_XOR;
          FUNCT_NOR:             alu_ctrl_o = ALU_NOR;
          FUNCT_SLT:             alu_ctrl_o = ALU_SLT;
          FUNCT_SLL:             alu_ctrl_o = ALU_SLL;
          FUNCT_SRL:             alu_ctrl_o = ALU_SRL;
          FUNCT_SRA:             alu_ctrl_o = ALU_SRA;
          FUNCT_SLLV:            alu_ctrl_o = ALU_SLLV;
          FUNCT_SRLV:            alu_ctrl_o = ALU_SRLV;
          FUNCT_SRAV:            alu_ctrl_o = ALU_SRAV;
          default:               alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/tl_execute_stage.sv
// MIPS EX stage: operand muxes, ALU, branch-target adder and the EX/MEM register.
module tl_execute_stage
  import tl_execute_stage_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  tl_execute_stage_if.slave   bus
);

  alu_op_e   alu_op;
  alu_ctrl_e alu_ctrl;
  logic      reg_dst;
  logic      alu_src;
  logic      unused_ctrl_ex;

  logic [LEN-1:0]                  operand_b;
  logic [LEN-1:0]                  alu_result;
  logic [LEN-1:0]                  branch_target;
  logic [NB_ADDRESS_REGISTROS-1:0] write_reg;

  logic                            alu_zero_q;
  logic [NB_ADDRESS_REGISTROS-1:0] write_reg_q;
  logic [NB_CTRL_WB-1:0]           ctrl_wb_q;
  logic [NB_CTRL_MEM-1:0]          ctrl_mem_q;
  logic [LEN-1:0]                  add_excute_q;
  logic [LEN-1:0]                  alu_result_q;
  logic [LEN-1:0]                  dato2_q;

  assign reg_dst        = bus.i_ctrl_ex[CTRL_EX_REG_DST];
  assign alu_src        = bus.i_ctrl_ex[CTRL_EX_ALU_SRC];
  assign alu_op         = alu_op_e'(bus.i_ctrl_ex[CTRL_EX_ALU_OP_HI:CTRL_EX_ALU_OP_LO]);
  assign unused_ctrl_ex = ^bus.i_ctrl_ex[1:0];

  always_comb begin
    write_reg     = reg_dst ? bus.i_rd : bus.i_rt;
    branch_target = bus.i_adder_id + (bus.i_sign_extend << 2);
    operand_b     = bus.i_dato2;
    if (alu_src) begin
      operand_b = is_logic_imm(alu_op) ? {{(LEN-16){1'b0}}, bus.i_sign_extend[15:0]}
                                       : bus.i_sign_extend;
    end
  end

  tl_execute_stage_alu_control u_alu_control (
    .alu_op_i   (alu_op),
    .funct_i    (bus.i_sign_extend[5:0]),
    .alu_ctrl_o (alu_ctrl)
  );

  tl_execute_stage_alu u_alu (
    .op_i     (alu_ctrl),
    .a_i      (bus.i_dato1),
    .b_i      (operand_b),
    .shamt_i  (bus.i_sign_extend[10:6]),
    .imm_i    (bus.i_sign_extend[15:0]),
    .result_o (alu_result)
  );

  // EX/MEM register: reset clears every field so MEM/WB see a harmless bubble.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (i_rst) begin
      alu_zero_q   <= 1'b0;
      write_reg_q  <= '0;
      ctrl_wb_q    <= '0;
      ctrl_mem_q   <= '0;
      add_excute_q <= '0;
      alu_result_q <= '0;
      dato2_q      <= '0;
    end else begin
      alu_zero_q   <= (alu_result == '0);
      write_reg_q  <= write_reg;
      ctrl_wb_q    <= bus.i_ctrl_wb;
      ctrl_mem_q   <= bus.i_ctrl_mem;
      add_excute_q <= branch_target;
      alu_result_q <= alu_result;
      dato2_q      <= bus.i_dato2;
    end
  end

  assign bus.o_alu_zero   = alu_zero_q;
  assign bus.o_write_reg  = write_reg_q;
  assign bus.o_ctrl_wb    = ctrl_wb_q;
  assign bus.o_ctrl_mem   = ctrl_mem_q;
  assign bus.o_add_excute = add_excute_q;
  assign bus.o_alu_result = alu_result_q;
  assign bus.o_dato2      = dato2_q;

endmodule

// File: tb/tb_tl_execute_stage.sv
// Scoreboard bench for tl_execute_stage: directed MIPS cases then random traffic,
// expected EX/MEM contents computed from instruction-level semantics.
module tb_tl_execute_stage;

  typedef struct packed {
    logic        zero;
    logic [4:0]  write_reg;
    logic [1:0]  ctrl_wb;
    logic [2:0]  ctrl_mem;
    logic [31:0] add;
    logic [31:0] result;
    logic [31:0] dato2;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  tl_execute_stage_if bus ();

  tl_execute_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Instruction-level reference: what the MIPS instruction computes.
  function automatic logic [31:0] ref_alu(input logic [2:0] alu_op, input logic alu_src,
                                          input logic [31:0] a, input logic [31:0] rt_val,
                                          input logic [31:0] imm);
    logic [31:0] b;
    logic [31:0] zimm;
    logic [4:0]  sh;
    logic [4:0]  va;
    zimm = {16'h0, imm[15:0]};
    b    = alu_src ? imm : rt_val;
    sh   = imm[10:6];
    va   = a[4:0];
    case (alu_op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd3: return a & (alu_src ? zimm : rt_val);
      3'd4: return a | (alu_src ? zimm : rt_val);
      3'd5: return a ^ (alu_src ? zimm : rt_val);
      3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd7: return {imm[15:0], 16'h0};
      default: begin
        case (imm[5:0])
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: return b << sh;
          6'h02: return b >> sh;
          6'h03: return $unsigned($signed(b) >>> sh);
          6'h04: return b << va;
          6'h06: return b >> va;
          6'h07: return $unsigned($signed(b) >>> va);
          default: return a + b;
        endcase
      end
    endcase
  endfunction

  // Drive one cycle of ID/EX inputs at the falling edge and queue the expected EX/MEM state.
  task automatic drive(input logic r, input logic [31:0] adder, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm, input logic [1:0] wb,
                       input logic [2:0] mem, input logic [6:0] ex, input logic [4:0] rd,
                       input logic [4:0] rt);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.i_adder_id    = adder;
    bus.i_dato1       = d1;
    bus.i_dato2       = d2;
    bus.i_sign_extend = imm;
    bus.i_ctrl_wb     = wb;
    bus.i_ctrl_mem    = mem;
    bus.i_ctrl_ex     = ex;
    bus.i_rd          = rd;
    bus.i_rt          = rt;
    if (r) begin
      e = '0;
    end else begin
      e.result    = ref_alu(ex[4:2], ex[5], d1, d2, imm);
      e.zero      = (e.result == 32'd0);
      e.write_reg = ex[6] ? rd : rt;
      e.ctrl_wb   = wb;
      e.ctrl_mem  = mem;
      e.add       = adder + imm * 4;
      e.dato2     = d2;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: the stage produces a new EX/MEM word every edge; compare one per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("alu_zero",   {31'h0, bus.o_alu_zero}, {31'h0, e.zero});
      check("write_reg",  {27'h0, bus.o_write_reg}, {27'h0, e.write_reg});
      check("ctrl_wb",    {30'h0, bus.o_ctrl_wb}, {30'h0, e.ctrl_wb});
      check("ctrl_mem",   {29'h0, bus.o_ctrl_mem}, {29'h0, e.ctrl_mem});
      check("add_excute", bus.o_add_excute, e.add);
      check("alu_result", bus.o_alu_result, e.result);
      check("dato2",      bus.o_dato2, e.dato2);
    end
  end

  initial begin
    logic [31:0] d1, d2, imm;
    logic [6:0]  ex;
    rst               = 1'b1;
    bus.i_adder_id    = '0;
    bus.i_dato1       = '0;
    bus.i_dato2       = '0;
    bus.i_sign_extend = '0;
    bus.i_ctrl_wb     = '0;
    bus.i_ctrl_mem    = '0;
    bus.i_ctrl_ex     = '0;
    bus.i_rd          = '0;
    bus.i_rt          = '0;

    // Reset held two cycles with busy inputs
    drive(1'b1, 32'h100, 32'h1234, 32'h5678, 32'h10, 2'b11, 3'b111, 7'b1_0_010_00, 5'd3, 5'd4);
    drive(1'b1, 32'h104, 32'hFFFF, 32'h1, 32'h20, 2'b10, 3'b101, 7'b0_1_000_00, 5'd6, 5'd8);
    // R-type add
    drive(1'b0, 32'd0, 32'd2, 32'd3, 32'h20, 2'b00, 3'b000, 7'b1_0_010_00, 5'd5, 5'd7);
    // beq, equal operands
    drive(1'b0, 32'd10, 32'd2, 32'd2, 32'h10, 2'b00, 3'b000, 7'b0_0_001_00, 5'd0, 5'd0);
    // lw
    drive(1'b0, 32'd0, 32'd2, 32'd77, 32'h10, 2'b11, 3'b101, 7'b0_1_000_00, 5'd1, 5'd9);
    // SRA shamt=4 on 0x80000000
    drive(1'b0, 32'd0, 32'd0, 32'h80000000, (32'd4 << 6) | 32'h03, 2'b01, 3'b000,
          7'b1_0_010_00, 5'd2, 5'd3);
    // slt -1 < 1
    drive(1'b0, 32'd0, 32'hFFFFFFFF, 32'd1, 32'h2A, 2'b01, 3'b000, 7'b1_0_010_00, 5'd4, 5'd5);
    // lui
    drive(1'b0, 32'd0, 32'h55, 32'd0, 32'h1234, 2'b01, 3'b000, 7'b0_1_111_00, 5'd6, 5'd7);
    // negative branch offset
    drive(1'b0, 32'd8, 32'd1, 32'd2, 32'hFFFFFFFF, 2'b00, 3'b000, 7'b0_0_001_00, 5'd0, 5'd0);
    // andi/ori/xori with negative immediate must use zero extension
    drive(1'b0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFF8001, 2'b01, 3'b000, 7'b0_1_011_00, 5'd1, 5'd2);
    drive(1'b0, 32'd0, 32'h0, 32'd0, 32'hFFFF8001, 2'b01, 3'b000, 7'b0_1_100_00, 5'd1, 5'd2);
    drive(1'b0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFF8001, 2'b01, 3'b000, 7'b0_1_101_00, 5'd1, 5'd2);
    // reset mid-stream dominates
    drive(1'b1, 32'd4, 32'd9, 32'd9, 32'h20, 2'b11, 3'b111, 7'b1_0_010_00, 5'd31, 5'd30);

    for (int i = 0; i < 400; i++) begin
      d1  = $urandom;
      d2  = ($urandom_range(0, 3) == 0) ? d1 : $urandom;
      imm = $urandom;
      if ($urandom_range(0, 1) == 1) imm = {{16{imm[15]}}, imm[15:0]};
      ex  = 7'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        ex[4:2] = 3'b010;
        case ($urandom_range(0, 3))
          0: imm[5:0] = 6'h00 + 6'($urandom_range(0, 7));
          1: imm[5:0] = 6'h20 + 6'($urandom_range(0, 10));
          default: imm[5:0] = 6'($urandom);
        endcase
      end
      drive(($urandom_range(0, 31) == 0), $urandom, d1, d2, imm, 2'($urandom), 3'($urandom),
            ex, 5'($urandom), 5'($urandom));
    end

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
